// File: rtl/md5_digest_check_if.sv
// rtl/md5_digest_check_if.sv - candidate/result bundle between MD5 core wrapper, digest checker and host
// MATCH_CNT exists only when MD5CHK_MATCH_CNT_EN is defined.
interface md5_digest_check_if #(
  parameter int ID_W = 32
);
  logic            IN_VALID;
  logic [31:0]     A_IN;
  logic [31:0]     B_IN;
  logic [31:0]     C_IN;
  logic [31:0]     D_IN;
  logic [31:0]     A_OUT;
  logic [31:0]     B_OUT;
  logic [31:0]     C_OUT;
  logic [31:0]     D_OUT;
  logic [127:0]    TARGET;
  logic            CLEAR;
  logic            DIGEST_VALID;
  logic [127:0]    DIGEST;
  logic [ID_W-1:0] DIGEST_ID;
  logic            MATCH;
  logic            FOUND;
  logic [ID_W-1:0] MATCH_ID;
`ifdef MD5CHK_MATCH_CNT_EN
  logic [15:0]     MATCH_CNT;
`endif

  modport master (
    output IN_VALID, A_IN, B_IN, C_IN, D_IN, A_OUT, B_OUT, C_OUT, D_OUT, TARGET, CLEAR,
    input  DIGEST_VALID, DIGEST, DIGEST_ID, MATCH, FOUND, MATCH_ID
`ifdef MD5CHK_MATCH_CNT_EN
    , MATCH_CNT
`endif
  );

  modport slave (
    input  IN_VALID, A_IN, B_IN, C_IN, D_IN, A_OUT, B_OUT, C_OUT, D_OUT, TARGET, CLEAR,
    output DIGEST_VALID, DIGEST, DIGEST_ID, MATCH, FOUND, MATCH_ID
`ifdef MD5CHK_MATCH_CNT_EN
    , MATCH_CNT
`endif
  );
endinterface

// File: rtl/md5_digest_check.sv
// rtl/md5_digest_check.sv - final MD5 chaining add, target compare and sticky match capture
// Define MD5CHK_MATCH_CNT_EN to add the saturating MATCH_CNT output.
module md5_digest_check #(
  parameter int LATENCY = 127,
  parameter int ID_W    = 32
) (
  input  logic               CLK,
  input  logic               RST,
  md5_digest_check_if.slave  bus
);

  localparam int DW = 128 + ID_W;

  logic [ID_W-1:0]    seq_q, seq_d;
  logic [LATENCY-1:0] vld_q;
  logic [DW-1:0]      dat_q [LATENCY];
  logic [DW-1:0]      dat_d;

  logic               tail_vld;
  logic [127:0]       tail_in;
  logic [ID_W-1:0]    tail_id;
  logic [127:0]       sum;
  logic               hit;

  logic               dv_q;
  logic [127:0]       digest_q;
  logic [ID_W-1:0]    did_q;
  logic               match_q;
  logic               found_q, found_d;
  logic [ID_W-1:0]    mid_q, mid_d;

  assign seq_d = bus.IN_VALID ? seq_q + ID_W'(1) : seq_q;
  assign dat_d = {bus.A_IN, bus.B_IN, bus.C_IN, bus.D_IN, seq_q};

  assign tail_vld = vld_q[LATENCY-1];
  assign tail_in  = dat_q[LATENCY-1][DW-1:ID_W];
  assign tail_id  = dat_q[LATENCY-1][ID_W-1:0];

  // Four independent 32-bit adds; carries never cross word boundaries.
  assign sum[127:96] = tail_in[127:96] + bus.A_OUT;
  assign sum[95:64]  = tail_in[95:64]  + bus.B_OUT;
  assign sum[63:32]  = tail_in[63:32]  + bus.C_OUT;
  assign sum[31:0]   = tail_in[31:0]   + bus.D_OUT;

  assign hit = tail_vld && (sum == bus.TARGET);

  // A match in the same cycle as CLEAR takes priority and re-arms with this ID.
  always_comb begin
    found_d = found_q;
    mid_d   = mid_q;
    if (hit && (!found_q || bus.CLEAR)) begin
      found_d = 1'b1;
      mid_d   = tail_id;
    end else if (bus.CLEAR) begin
      found_d = 1'b0;
      mid_d   = '0;
    end
  end

  // Data line carries no reset: stale payload is harmless once the valid line is clear.
  always_ff @(posedge CLK) begin
    dat_q[0] <= dat_d;
    for (int i = 1; i < LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      seq_q    <= '0;
      vld_q    <= '0;
      dv_q     <= 1'b0;
      digest_q <= '0;
      did_q    <= '0;
      match_q  <= 1'b0;
      found_q  <= 1'b0;
      mid_q    <= '0;
    end else begin
      seq_q    <= seq_d;
      vld_q[0] <= bus.IN_VALID;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      dv_q    <= tail_vld;
      match_q <= hit;
      if (tail_vld) begin
        digest_q <= sum;
        did_q    <= tail_id;
      end
      found_q <= found_d;
      mid_q   <= mid_d;
    end
  end

  assign bus.DIGEST_VALID = dv_q;
  assign bus.DIGEST       = digest_q;
  assign bus.DIGEST_ID    = did_q;
  assign bus.MATCH        = match_q;
  assign bus.FOUND        = found_q;
  assign bus.MATCH_ID     = mid_q;

`ifdef MD5CHK_MATCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.CLEAR) begin
      cnt_d = {15'd0, hit};
    end else if (hit && (cnt_q != 16'hffff)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.MATCH_CNT = cnt_q;
`else
  // Match counter is not built in this configuration.
`endif

endmodule
